// File: rtl/button_event_scheduler.sv
// Debounced multi-key press/auto-repeat event source with round-robin
// arbitration into a small valid/ready event FIFO.
//
// Ports:
//   clk          single clock
//   reset        asynchronous active-high reset
//   keys         raw button levels, 1 = pressed
//   event_valid  FIFO head holds an event
//   event_ready  consumer takes the head when event_valid is also 1
//   event_key    key index of the head event
//   event_repeat head is an auto-repeat (0 = initial press)
//   drop_flag    sticky, set once any event has been discarded
module button_event_scheduler #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [$clog2(NUM_KEYS)-1:0] event_key,
  output logic                        event_repeat,
  output logic                        drop_flag
);
  localparam int KW   = $clog2(NUM_KEYS);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [KW-1:0] KEY_LAST = KW'(NUM_KEYS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_KEYS-1:0] acc_q, acc_d;
  logic [DW-1:0]       db_q  [NUM_KEYS];
  logic [DW-1:0]       db_d  [NUM_KEYS];
  logic [TW-1:0]       tmr_q [NUM_KEYS];
  logic [TW-1:0]       tmr_d [NUM_KEYS];
  state_t              st_q  [NUM_KEYS];
  state_t              st_d  [NUM_KEYS];
  logic [NUM_KEYS-1:0] ev_q, ev_d, evr_q, evr_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d, prep_q, prep_d;
  logic [NUM_KEYS-1:0] grant, drop_v;
  logic [KW-1:0]       ptr_q, ptr_d, idx, gnt;
  logic                found, push, pop;
  logic [KW:0]         mem_q [FIFO_DEPTH];
  logic [KW:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                drop_q, drop_d;

  always_comb begin
    s1_d = keys;
    s2_d = s1_q;

    // Round-robin search starting one past the last granted key.
    idx   = ptr_q;
    gnt   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = (idx == KEY_LAST) ? '0 : idx + KW'(1);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    push  = found && (cnt_q < DEPTH);
    grant = '0;
    if (push) grant[gnt] = 1'b1;
    ptr_d = push ? gnt : ptr_q;

    drop_v = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      acc_d[i] = acc_q[i];
      db_d[i]  = '0;
      if (s2_q[i] != acc_q[i]) begin
        if (db_q[i] == DB_LAST) acc_d[i] = s2_q[i];
        else db_d[i] = db_q[i] + DW'(1);
      end

      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      ev_d[i]  = 1'b0;
      evr_d[i] = 1'b0;
      unique case (st_q[i])
        IDLE: begin
          if (acc_q[i]) begin
            st_d[i]  = DELAY;
            tmr_d[i] = '0;
            ev_d[i]  = 1'b1;
          end
        end
        DELAY: begin
          if (tmr_q[i] == DLY_LAST) begin
            st_d[i]  = REPEAT;
            tmr_d[i] = '0;
            ev_d[i]  = 1'b1;
            evr_d[i] = 1'b1;
          end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
          end
          // A timer expiry this cycle still emits its event.
          if (!acc_q[i]) begin
            st_d[i]  = IDLE;
            tmr_d[i] = '0;
          end
        end
        REPEAT: begin
          if (tmr_q[i] == PER_LAST) begin
            tmr_d[i] = '0;
            ev_d[i]  = 1'b1;
            evr_d[i] = 1'b1;
          end else begin
            tmr_d[i] = tmr_q[i] + TW'(1);
          end
          if (!acc_q[i]) begin
            st_d[i]  = IDLE;
            tmr_d[i] = '0;
          end
        end
        default: begin
          st_d[i]  = IDLE;
          tmr_d[i] = '0;
        end
      endcase

      // A grant and a new event in the same cycle keep the new one.
      pend_d[i] = (pend_q[i] & ~grant[i]) | ev_q[i];
      prep_d[i] = ev_q[i] ? evr_q[i] : prep_q[i];
      drop_v[i] = ev_q[i] & pend_q[i] & ~grant[i];
    end
    drop_d = drop_q | (|drop_v);

    pop   = (cnt_q != '0) && event_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {gnt, prep_q[gnt]};
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      acc_q  <= '0;
      ev_q   <= '0;
      evr_q  <= '0;
      pend_q <= '0;
      prep_q <= '0;
      ptr_q  <= KEY_LAST;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_q[i]  <= '0;
        tmr_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      acc_q  <= acc_d;
      ev_q   <= ev_d;
      evr_q  <= evr_d;
      pend_q <= pend_d;
      prep_q <= prep_d;
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_q[i]  <= db_d[i];
        tmr_q[i] <= tmr_d[i];
        st_q[i]  <= st_d[i];
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= mem_d[j];
    end
  end

  assign event_valid  = (cnt_q != '0);
  assign event_key    = event_valid ? mem_q[rd_q][KW:1] : '0;
  assign event_repeat = event_valid & mem_q[rd_q][0];
  assign drop_flag    = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scenario bench for button_event_scheduler: expected events are queued
// with their due cycle as keys are driven and matched as the DUT emits.
module tb_button_event_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_key;
  logic       event_repeat;
  logic       drop_flag;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int cyc;
    int key;
    bit rep;
  } exp_t;
  exp_t exp_q[$];

  button_event_scheduler #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys(keys),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_key(event_key),
    .event_repeat(event_repeat),
    .drop_flag(drop_flag)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int c, int k, bit r);
    exp_t e;
    e.cyc = c;
    e.key = k;
    e.rep = r;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    keys = '0;
    event_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (event_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", event_valid);
    else passed++;
    total++;
    if (event_key !== 2'd0)
      $display("FAIL rst_key: got %0d want 0", event_key);
    else passed++;
    total++;
    if (event_repeat !== 1'b0)
      $display("FAIL rst_repeat: got %b want 0", event_repeat);
    else passed++;
    total++;
    if (drop_flag !== 1'b0)
      $display("FAIL rst_drop: got %b want 0", drop_flag);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    int seen = 0;
    @(negedge clk);
    keys = 4'b0100;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) keys = 4'b0000;
      if (event_valid) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL glitch_events: got %0d want 0", seen);
    else passed++;
    total++;
    if (drop_flag !== 1'b0)
      $display("FAIL glitch_drop: got %b want 0", drop_flag);
    else passed++;
  endtask

  task automatic test_press_repeat();
    exp_t e;
    exp_q = {};
    exp_q.push_back(mk(9, 1, 1'b0));
    exp_q.push_back(mk(29, 1, 1'b1));
    exp_q.push_back(mk(37, 1, 1'b1));
    exp_q.push_back(mk(45, 1, 1'b1));
    exp_q.push_back(mk(53, 1, 1'b1));
    @(negedge clk);
    keys = 4'b0010;
    for (int n = 1; n <= 62; n++) begin
      @(negedge clk);
      if (event_valid && event_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL press_ev: got n=%0d key=%0d rep=%0d want none",
                   n, event_key, event_repeat);
        end else begin
          e = exp_q.pop_front();
          if (n != e.cyc || int'(event_key) != e.key ||
              event_repeat !== e.rep)
            $display("FAIL press_ev: got n=%0d k=%0d r=%0d want %0d %0d %0d",
                     n, event_key, event_repeat, e.cyc, e.key, e.rep);
          else passed++;
        end
      end
      if (n == 45) keys = 4'b0000;
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL press_left: got %0d missing want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q = {};
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(9 + k, k, 1'b0));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(39 + k, k, 1'b0));
    @(negedge clk);
    keys = 4'b1111;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (event_valid && event_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL burst_ev: got n=%0d key=%0d rep=%0d want none",
                   n, event_key, event_repeat);
        end else begin
          e = exp_q.pop_front();
          if (n != e.cyc || int'(event_key) != e.key ||
              event_repeat !== e.rep)
            $display("FAIL burst_ev: got n=%0d k=%0d r=%0d want %0d %0d %0d",
                     n, event_key, event_repeat, e.cyc, e.key, e.rep);
          else passed++;
        end
      end
      if (n == 12 || n == 42) keys = 4'b0000;
      if (n == 30) keys = 4'b1111;
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL burst_left: got %0d missing want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_fifo_full();
    exp_t e;
    exp_q = {};
    exp_q.push_back(mk(30, 0, 1'b0));
    exp_q.push_back(mk(31, 1, 1'b0));
    exp_q.push_back(mk(32, 2, 1'b0));
    exp_q.push_back(mk(33, 3, 1'b0));
    exp_q.push_back(mk(34, 0, 1'b1));
    exp_q.push_back(mk(37, 0, 1'b1));
    @(negedge clk);
    event_ready = 1'b0;
    keys = 4'b1111;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      if (n == 20 || n == 29) begin
        total++;
        if (event_valid !== 1'b1 || event_key !== 2'd0 ||
            event_repeat !== 1'b0)
          $display("FAIL full_head: got v=%b k=%0d r=%b want 1 0 0",
                   event_valid, event_key, event_repeat);
        else passed++;
      end
      if (n == 29) begin
        total++;
        if (drop_flag !== 1'b0)
          $display("FAIL full_nodrop: got %b want 0", drop_flag);
        else passed++;
      end
      if (n == 30) event_ready = 1'b1;
      if (event_valid && event_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL drain_ev: got n=%0d key=%0d rep=%0d want none",
                   n, event_key, event_repeat);
        end else begin
          e = exp_q.pop_front();
          if (n != e.cyc || int'(event_key) != e.key ||
              event_repeat !== e.rep)
            $display("FAIL drain_ev: got n=%0d k=%0d r=%0d want %0d %0d %0d",
                     n, event_key, event_repeat, e.cyc, e.key, e.rep);
          else passed++;
        end
      end
      if (n == 12) keys = 4'b0001;
      if (n == 34) keys = 4'b0000;
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain_left: got %0d missing want 0", exp_q.size());
    else passed++;
    total++;
    if (drop_flag !== 1'b0)
      $display("FAIL drain_drop: got %b want 0", drop_flag);
    else passed++;
  endtask

  task automatic test_drop();
    @(negedge clk);
    event_ready = 1'b0;
    keys = 4'b1111;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 12) keys = 4'b0001;
      if (n == 35) begin
        total++;
        if (drop_flag !== 1'b0)
          $display("FAIL drop_early: got %b want 0", drop_flag);
        else passed++;
      end
      if (n == 36 || n == 50) begin
        total++;
        if (drop_flag !== 1'b1)
          $display("FAIL drop_set: got %b want 1 at n=%0d", drop_flag, n);
        else passed++;
      end
    end
    total++;
    if (event_valid !== 1'b1 || event_key !== 2'd1)
      $display("FAIL drop_head: got v=%b k=%0d want 1 1",
               event_valid, event_key);
    else passed++;
    keys = 4'b0000;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (drop_flag !== 1'b0)
      $display("FAIL mid_dropclr: got %b want 0", drop_flag);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    event_ready = 1'b0;
    keys = 4'b1000;
    for (int n = 1; n <= 30; n++) @(negedge clk);
    total++;
    if (event_valid !== 1'b1 || event_key !== 2'd3 ||
        event_repeat !== 1'b0)
      $display("FAIL mid_head: got v=%b k=%0d r=%b want 1 3 0",
               event_valid, event_key, event_repeat);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (event_valid !== 1'b0 || event_key !== 2'd0 ||
        event_repeat !== 1'b0)
      $display("FAIL mid_async: got v=%b k=%0d r=%b want 0 0 0",
               event_valid, event_key, event_repeat);
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    event_ready = 1'b1;
    exp_q = {};
    exp_q.push_back(mk(9, 3, 1'b0));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (event_valid && event_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL mid_ev: got n=%0d key=%0d rep=%0d want none",
                   n, event_key, event_repeat);
        end else begin
          e = exp_q.pop_front();
          if (n != e.cyc || int'(event_key) != e.key ||
              event_repeat !== e.rep)
            $display("FAIL mid_ev: got n=%0d k=%0d r=%0d want %0d %0d %0d",
                     n, event_key, event_repeat, e.cyc, e.key, e.rep);
          else passed++;
        end
      end
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL mid_left: got %0d missing want 0", exp_q.size());
    else passed++;
    keys = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_repeat();
    test_simultaneous();
    test_fifo_full();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
